// File: rtl/egm_latency_monitor.sv
// EGM stimulus-to-response latency monitor: measures clock cycles from a stimulus
// rising edge to the handler's response rising edge and keeps worst-case/event statistics.
module egm_latency_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 50000,
    parameter int EVT_W   = 16
) (
    input  logic             clkin_50,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             stimulus,
    input  logic             response,
    output logic [CNT_W-1:0] latency,
    output logic             latency_valid,
    output logic [CNT_W-1:0] max_latency,
    output logic [EVT_W-1:0] pulse_count,
    output logic [EVT_W-1:0] missed_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DONE      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);
    localparam logic [EVT_W-1:0] EVT_MAX  = {EVT_W{1'b1}};

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] value);
        if (value == EVT_MAX) begin
            sat_inc = value;
        end else begin
            sat_inc = value + EVT_ONE;
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stim_d_r;
    logic             resp_d_r;
    logic             stim_rise_s;
    logic             resp_rise_s;
    logic             accept_s;
    logic             answer_s;
    logic [CNT_W-1:0] answer_lat_s;
    logic             miss_s;
    logic [CNT_W-1:0] latency_r;
    logic             latency_valid_r;
    logic [CNT_W-1:0] max_latency_r;
    logic [EVT_W-1:0] pulse_count_r;
    logic [EVT_W-1:0] missed_count_r;
    logic             busy_r;

    assign stim_rise_s = stimulus & ~stim_d_r;
    assign resp_rise_s = response & ~resp_d_r;

    // Edge-detect history; preset high so a level already high at reset release is no edge.
    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            stim_d_r <= 1'b1;
            resp_d_r <= 1'b1;
        end else begin
            stim_d_r <= stimulus;
            resp_d_r <= response;
        end
    end

    // Next-state, cycle counter and per-cycle statistic update requests.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        accept_s     = 1'b0;
        answer_s     = 1'b0;
        answer_lat_s = {CNT_W{1'b0}};
        miss_s       = 1'b0;
        if (!enable) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (stim_rise_s) begin
                        accept_s  = 1'b1;
                        cnt_nxt_s = {CNT_W{1'b0}};
                        if (resp_rise_s) begin
                            answer_s    = 1'b1;
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = WAIT_RESP;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                WAIT_RESP: begin
                    // Stimulus falling here is deliberately ignored; only the response matters.
                    if (resp_rise_s) begin
                        answer_s     = 1'b1;
                        answer_lat_s = cnt_r + CNT_ONE;
                        state_nxt_s  = DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        miss_s      = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (!stimulus && !response) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // FSM state and cycle counter registers.
    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == WAIT_RESP);
        end
    end

    // Statistics; clear wins over any update landing in the same cycle.
    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            latency_r       <= {CNT_W{1'b0}};
            latency_valid_r <= 1'b0;
            max_latency_r   <= {CNT_W{1'b0}};
            pulse_count_r   <= {EVT_W{1'b0}};
            missed_count_r  <= {EVT_W{1'b0}};
        end else if (clear) begin
            latency_r       <= {CNT_W{1'b0}};
            latency_valid_r <= 1'b0;
            max_latency_r   <= {CNT_W{1'b0}};
            pulse_count_r   <= {EVT_W{1'b0}};
            missed_count_r  <= {EVT_W{1'b0}};
        end else begin
            latency_valid_r <= answer_s;
            if (answer_s) begin
                latency_r <= answer_lat_s;
                if (answer_lat_s > max_latency_r) begin
                    max_latency_r <= answer_lat_s;
                end
            end
            if (accept_s) begin
                pulse_count_r <= sat_inc(pulse_count_r);
            end
            if (miss_s) begin
                missed_count_r <= sat_inc(missed_count_r);
            end
        end
    end

    assign latency       = latency_r;
    assign latency_valid = latency_valid_r;
    assign max_latency   = max_latency_r;
    assign pulse_count   = pulse_count_r;
    assign missed_count  = missed_count_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_egm_latency_monitor.sv
// Self-checking bench for egm_latency_monitor: directed scenarios plus randomized
// events compared against an event-level model of latency/timeout statistics.
module tb_egm_latency_monitor;

    localparam int TO  = 100;
    localparam int TO2 = 4;

    logic        clkin_50 = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        clear = 1'b0;
    logic        stimulus = 1'b0;
    logic        response = 1'b0;
    logic [15:0] latency;
    logic        latency_valid;
    logic [15:0] max_latency;
    logic [15:0] pulse_count;
    logic [15:0] missed_count;
    logic        busy;

    // Second instance with narrow counters so saturation is reachable in a short run.
    logic        stim2 = 1'b0;
    logic        resp2 = 1'b0;
    logic [15:0] latency2;
    logic        latency_valid2;
    logic [15:0] max_latency2;
    logic [7:0]  pulse_count2;
    logic [7:0]  missed_count2;
    logic        busy2;

    int checks = 0;
    int failures = 0;

    int exp_lat, exp_max, exp_pulse, exp_missed;

    always #10 clkin_50 = ~clkin_50;

    egm_latency_monitor #(.CNT_W(16), .TIMEOUT(TO), .EVT_W(16)) dut (
        .clkin_50(clkin_50), .rst(rst), .enable(enable), .clear(clear),
        .stimulus(stimulus), .response(response), .latency(latency),
        .latency_valid(latency_valid), .max_latency(max_latency),
        .pulse_count(pulse_count), .missed_count(missed_count), .busy(busy)
    );

    egm_latency_monitor #(.CNT_W(16), .TIMEOUT(TO2), .EVT_W(8)) dut_sat (
        .clkin_50(clkin_50), .rst(rst), .enable(1'b1), .clear(1'b0),
        .stimulus(stim2), .response(resp2), .latency(latency2),
        .latency_valid(latency_valid2), .max_latency(max_latency2),
        .pulse_count(pulse_count2), .missed_count(missed_count2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clkin_50);
        #1;
    endtask

    task automatic do_reset();
        stimulus = 1'b0; response = 1'b0; clear = 1'b0; enable = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        exp_lat = 0; exp_max = 0; exp_pulse = 0; exp_missed = 0;
    endtask

    // Event-level reference: answered if response edge arrives within TO cycles.
    function automatic void model_event(input int l);
        if (exp_pulse < 65535) exp_pulse++;
        if (l <= TO) begin
            exp_lat = l;
            if (l > exp_max) exp_max = l;
        end else begin
            if (exp_missed < 65535) exp_missed++;
        end
    endfunction

    // Stimulus rise, then response rise l cycles later (l > TO: never respond).
    // Returns #1 after the cycle where the outcome is recorded.
    task automatic run_event(input int l, input bit drop_stim);
        stimulus = 1'b1;
        response = (l == 0);
        tick();
        if (drop_stim) stimulus = 1'b0;
        if (l > TO) begin
            repeat (TO) tick();
        end else if (l > 0) begin
            repeat (l - 1) tick();
            response = 1'b1;
            tick();
        end
    endtask

    task automatic end_event();
        stimulus = 1'b0; response = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (latency !== 16'd0) begin failures++; $display("FAIL reset_latency got=%0d exp=0", latency); end
        checks++; if (latency_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", latency_valid); end
        checks++; if (max_latency !== 16'd0) begin failures++; $display("FAIL reset_max got=%0d exp=0", max_latency); end
        checks++; if (pulse_count !== 16'd0) begin failures++; $display("FAIL reset_pulse got=%0d exp=0", pulse_count); end
        checks++; if (missed_count !== 16'd0) begin failures++; $display("FAIL reset_missed got=%0d exp=0", missed_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_basic();
        do_reset();
        repeat (6) tick();
        stimulus = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%0b exp=1", busy); end
        repeat (6) tick();
        checks++; if (latency_valid !== 1'b0) begin failures++; $display("FAIL t1_early_valid got=%0b exp=0", latency_valid); end
        response = 1'b1;
        tick();
        checks++; if (latency_valid !== 1'b1) begin failures++; $display("FAIL t1_valid got=%0b exp=1", latency_valid); end
        checks++; if (latency !== 16'd7) begin failures++; $display("FAIL t1_latency got=%0d exp=7", latency); end
        checks++; if (max_latency !== 16'd7) begin failures++; $display("FAIL t1_max got=%0d exp=7", max_latency); end
        checks++; if (pulse_count !== 16'd1) begin failures++; $display("FAIL t1_pulse got=%0d exp=1", pulse_count); end
        checks++; if (missed_count !== 16'd0) begin failures++; $display("FAIL t1_missed got=%0d exp=0", missed_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_done got=%0b exp=0", busy); end
        end_event();
        checks++; if (latency_valid !== 1'b0) begin failures++; $display("FAIL t1_valid_one_cycle got=%0b exp=0", latency_valid); end
    endtask

    task automatic test_zero_latency();
        do_reset();
        run_event(0, 1'b0);
        checks++; if (latency_valid !== 1'b1) begin failures++; $display("FAIL t2_valid got=%0b exp=1", latency_valid); end
        checks++; if (latency !== 16'd0) begin failures++; $display("FAIL t2_latency got=%0d exp=0", latency); end
        checks++; if (pulse_count !== 16'd1) begin failures++; $display("FAIL t2_pulse got=%0d exp=1", pulse_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_busy got=%0b exp=0", busy); end
        end_event();
    endtask

    task automatic test_timeout();
        do_reset();
        stimulus = 1'b1;
        tick();
        repeat (TO - 1) tick();
        checks++; if (missed_count !== 16'd0) begin failures++; $display("FAIL t3_missed_early got=%0d exp=0", missed_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t3_busy_wait got=%0b exp=1", busy); end
        tick();
        checks++; if (missed_count !== 16'd1) begin failures++; $display("FAIL t3_missed got=%0d exp=1", missed_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t3_busy_done got=%0b exp=0", busy); end
        checks++; if (latency_valid !== 1'b0 || latency !== 16'd0) begin failures++; $display("FAIL t3_latency got=%0d/%0b exp=0/0", latency, latency_valid); end
        // Still in DONE while stimulus is high: a response edge records nothing.
        response = 1'b1; tick(); response = 1'b0; tick(); tick();
        checks++; if (latency !== 16'd0) begin failures++; $display("FAIL t3_done_hold got=%0d exp=0", latency); end
        stimulus = 1'b0; tick();
        run_event(3, 1'b0);
        checks++; if (latency !== 16'd3 || pulse_count !== 16'd2) begin failures++; $display("FAIL t3_rearm got=%0d/%0d exp=3/2", latency, pulse_count); end
        end_event();
        run_event(TO, 1'b0);
        checks++; if (latency !== 16'(TO) || missed_count !== 16'd1) begin failures++; $display("FAIL t3_boundary got=%0d/%0d exp=%0d/1", latency, missed_count, TO); end
        end_event();
    endtask

    task automatic test_max_tracking();
        int lats [4] = '{20, 5, 33, 12};
        int maxs [4] = '{20, 20, 33, 33};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_event(lats[i], 1'b0);
            checks++; if (max_latency !== 16'(maxs[i]) || latency !== 16'(lats[i])) begin
                failures++; $display("FAIL t4_max[%0d] got=%0d/%0d exp=%0d/%0d", i, max_latency, latency, maxs[i], lats[i]);
            end
            end_event();
        end
        checks++; if (pulse_count !== 16'd4) begin failures++; $display("FAIL t4_pulse got=%0d exp=4", pulse_count); end
    endtask

    task automatic test_clear();
        do_reset();
        run_event(15, 1'b0);
        end_event();
        stimulus = 1'b1;
        tick(); tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0;
        checks++; if (latency !== 16'd0 || max_latency !== 16'd0 || pulse_count !== 16'd0 || missed_count !== 16'd0) begin
            failures++; $display("FAIL t5_cleared got=%0d/%0d/%0d/%0d exp=0/0/0/0", latency, max_latency, pulse_count, missed_count);
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t5_busy got=%0b exp=1", busy); end
        repeat (5) tick();
        response = 1'b1; tick();
        checks++; if (latency_valid !== 1'b1 || latency !== 16'd9 || max_latency !== 16'd9 || pulse_count !== 16'd0) begin
            failures++; $display("FAIL t5_after got=%0b/%0d/%0d/%0d exp=1/9/9/0", latency_valid, latency, max_latency, pulse_count);
        end
        end_event();
        // Clear coinciding with a response edge: clear wins.
        stimulus = 1'b1; tick(); tick();
        response = 1'b1; clear = 1'b1; tick(); clear = 1'b0;
        checks++; if (latency_valid !== 1'b0 || latency !== 16'd0 || max_latency !== 16'd0 || pulse_count !== 16'd0) begin
            failures++; $display("FAIL t5_priority got=%0b/%0d/%0d/%0d exp=0/0/0/0", latency_valid, latency, max_latency, pulse_count);
        end
        end_event();
    endtask

    task automatic test_edge_enable();
        stimulus = 1'b1; rst = 1'b1; tick(); tick();
        rst = 1'b0; repeat (3) tick();
        checks++; if (pulse_count !== 16'd0 || busy !== 1'b0) begin failures++; $display("FAIL t6_reset_high got=%0d/%0b exp=0/0", pulse_count, busy); end
        stimulus = 1'b0; tick();
        stimulus = 1'b1; tick();
        repeat (4) tick();
        enable = 1'b0; tick();
        checks++; if (busy !== 1'b0 || pulse_count !== 16'd1 || missed_count !== 16'd0) begin
            failures++; $display("FAIL t6_disable got=%0b/%0d/%0d exp=0/1/0", busy, pulse_count, missed_count);
        end
        repeat (3) tick();
        enable = 1'b1; tick(); tick();
        checks++; if (busy !== 1'b0 || pulse_count !== 16'd1) begin failures++; $display("FAIL t6_reenable got=%0b/%0d exp=0/1", busy, pulse_count); end
        response = 1'b1; tick(); tick();
        repeat (TO + 10) tick();
        checks++; if (latency !== 16'd0 || missed_count !== 16'd0) begin failures++; $display("FAIL t6_abandon got=%0d/%0d exp=0/0", latency, missed_count); end
        end_event();
        enable = 1'b0;
        stimulus = 1'b1; tick(); tick();
        checks++; if (pulse_count !== 16'd1) begin failures++; $display("FAIL t6_disabled_edge got=%0d exp=1", pulse_count); end
        enable = 1'b1;
        end_event();
    endtask

    task automatic test_random();
        int l;
        bit drop;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(TO + 1, TO + 20) : $urandom_range(0, TO);
            drop = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) tick();
            run_event(l, drop);
            model_event(l);
            checks++; if (latency_valid !== (l <= TO) || latency !== 16'(exp_lat) || max_latency !== 16'(exp_max)) begin
                failures++; $display("FAIL rnd_lat[%0d] l=%0d got=%0b/%0d/%0d exp=%0b/%0d/%0d", i, l, latency_valid, latency, max_latency, (l <= TO), exp_lat, exp_max);
            end
            checks++; if (pulse_count !== 16'(exp_pulse) || missed_count !== 16'(exp_missed) || busy !== 1'b0) begin
                failures++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d/%0b exp=%0d/%0d/0", i, pulse_count, missed_count, busy, exp_pulse, exp_missed);
            end
            end_event();
        end
    endtask

    task automatic test_saturation();
        int n_exp;
        do_reset();
        for (int i = 1; i <= 257; i++) begin
            stim2 = 1'b1; resp2 = 1'b1; tick();
            stim2 = 1'b0; resp2 = 1'b0; tick();
            n_exp = (i > 255) ? 255 : i;
            if (i >= 254) begin
                checks++; if (pulse_count2 !== 8'(n_exp)) begin failures++; $display("FAIL sat_pulse[%0d] got=%0d exp=%0d", i, pulse_count2, n_exp); end
            end
        end
        for (int i = 1; i <= 257; i++) begin
            stim2 = 1'b1; tick();
            repeat (TO2) tick();
            stim2 = 1'b0; tick();
        end
        checks++; if (missed_count2 !== 8'hFF || pulse_count2 !== 8'hFF) begin
            failures++; $display("FAIL sat_missed got=%0d/%0d exp=255/255", missed_count2, pulse_count2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_latency();
        test_timeout();
        test_max_tracking();
        test_clear();
        test_edge_enable();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
